// File: rtl/mux_select_arbiter.sv
// mux_select_arbiter
//   Round-robin arbiter that shares one 4:1 single-bit mux among four
//   requesters. The owner's index drives the mux select lines. A grant
//   lasts at most MAXBURST cycles. It releases earlier on done or when
//   the owner drops its request.
//
// Optional build macro: MUX_ARB_LOCK_EN
//   When defined, this adds a 'lock' input. While lock and req[owner]
//   are both high, the burst limit is suppressed.
//
// Ports:
//   clk       rising-edge clock
//   reset_n   asynchronous active-low reset
//   req[3:0]  one request per requester; req[i] owns mux input i
//   done      owner releases early; ignored when idle
//   lock      (MUX_ARB_LOCK_EN only) holds the grant past MAXBURST
//   address0  mux select LSB (owner index bit 0)
//   address1  mux select MSB (owner index bit 1)
//   grant     one-hot owner, 0000 when idle
//   busy      high while a grant is active
module mux_select_arbiter #(
  parameter int MAXBURST = 4,
  parameter int CNTW     = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] req,
  input  logic       done,
`ifdef MUX_ARB_LOCK_EN
  input  logic       lock,
`endif
  output logic       address0,
  output logic       address1,
  output logic [3:0] grant,
  output logic       busy
);

  localparam logic [0:0]      IDLE = 1'b0;
  localparam logic [0:0]      OWN  = 1'b1;
  localparam logic [CNTW-1:0] LAST = CNTW'(MAXBURST - 1);

  logic [0:0]      state;
  logic [1:0]      ptr;
  logic [CNTW-1:0] cnt;
  logic [1:0]      owner;
  logic            owner_req;
  logic            hit_last;
  logic            lock_hold;
  logic            rel;
  logic [1:0]      base;
  logic [1:0]      win;
  logic            win_vld;

  // The select lines are the only record of the owner index. This is
  // why they hold their value through IDLE.
  assign owner     = {address1, address0};
  assign owner_req = req[owner];
  assign hit_last  = (cnt == LAST);

`ifdef MUX_ARB_LOCK_EN
  assign lock_hold = lock & owner_req;
`else
  assign lock_hold = 1'b0;
`endif

  assign rel = (state == OWN) && (!owner_req || done || (hit_last && !lock_hold));

  // On release the search starts at the rotated pointer on the same edge.
  // This allows a back-to-back grant with no idle cycle.
  assign base = (state == OWN) ? owner + 2'd1 : ptr;

  // First set request at or after 'base'. The loop runs from the highest
  // offset down, so the lowest offset written last wins.
  always_comb begin
    logic [1:0] idx;
    win_vld = 1'b0;
    win     = base;
    idx     = base;
    for (int i = 3; i >= 0; i--) begin
      idx = base + 2'(i);
      if (req[idx]) begin
        win_vld = 1'b1;
        win     = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      ptr      <= 2'd0;
      cnt      <= '0;
      grant    <= 4'b0000;
      busy     <= 1'b0;
      address0 <= 1'b0;
      address1 <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (win_vld) begin
            state    <= OWN;
            grant    <= 4'b0001 << win;
            address0 <= win[0];
            address1 <= win[1];
            busy     <= 1'b1;
            cnt      <= '0;
          end
        end
        default: begin
          if (rel) begin
            ptr <= owner + 2'd1;
            if (win_vld) begin
              grant    <= 4'b0001 << win;
              address0 <= win[0];
              address1 <= win[1];
              cnt      <= '0;
            end else begin
              state <= IDLE;
              grant <= 4'b0000;
              busy  <= 1'b0;
            end
          end else if (!(lock_hold && hit_last)) begin
            // When locked, the counter saturates at LAST. Otherwise it
            // never reaches this branch at LAST, because LAST releases.
            cnt <= cnt + CNTW'(1);
          end
        end
      endcase
    end
  end

endmodule
